mmcm_sweep_ctrl: RTL and testbench

//   Upstream sequencer for the xilinx7_reconfig DRP engine.
//   - Steps the MMCM CLKOUT0 half-period through [HP_MIN..HP_MAX].
//   - For each value: requests a reconfiguration, waits for reconfig_done and MMCM lock
//     (with timeout), dwells, then advances.
//   - Replaces the ad-hoc counter/start logic in top-levels; runs on the DRP clock (dclk).

---
 rtl/mmcm_sweep_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_mmcm_sweep_ctrl.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/mmcm_sweep_ctrl.sv
// Sweep sequencer for the MMCM DRP reconfiguration engine: steps CLKOUT0 half-period through
// [HP_MIN..HP_MAX], requesting a reconfig, waiting for done/lock (with timeout), then dwelling.
module mmcm_sweep_ctrl #(
  parameter int unsigned HP_MIN       = 10,
  parameter int unsigned HP_MAX       = 20,
  parameter int unsigned DWELL_CYCLES = 2**24,
  parameter int unsigned LOCK_TIMEOUT = 65536,
  parameter int unsigned BOUNCE       = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        ready,
  input  logic        reconfig_done,
  input  logic        locked,
  output logic [5:0]  half_period,
  output logic        start_reconfig,
  output logic        busy,
  output logic [15:0] step_count,
  output logic        lock_fail,
  output logic [7:0]  fail_count
);

  // Widths sized with +1 so a count of 1 never yields a zero-width counter.
  localparam int unsigned TW = $clog2(LOCK_TIMEOUT + 1);
  localparam int unsigned DW = $clog2(DWELL_CYCLES + 1);

  localparam logic [5:0]    HpMin     = 6'(HP_MIN);
  localparam logic [5:0]    HpMax     = 6'(HP_MAX);
  localparam logic [TW-1:0] TmoLast   = TW'(LOCK_TIMEOUT - 1);
  localparam logic [DW-1:0] DwellLast = DW'(DWELL_CYCLES - 1);

  typedef enum logic [2:0] {
    StIdle,
    StReq,
    StWaitDone,
    StWaitLock,
    StDwell,
    StAdvance
  } state_e;

  state_e        state_q, state_d;
  logic [5:0]    hp_q, hp_d;
  logic          dir_up_q, dir_up_d;
  logic          start_q, start_d;
  logic          busy_q, busy_d;
  logic [15:0]   step_q, step_d;
  logic          fail_flag_q, fail_flag_d;
  logic [7:0]    fail_cnt_q, fail_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [DW-1:0] dwell_q, dwell_d;

  logic [5:0]    hp_adv;
  logic          dir_adv;
  logic          tmo_hit;

  // Next half-period value applied when leaving ADVANCE.
  always_comb begin
    hp_adv  = hp_q;
    dir_adv = dir_up_q;
    if (HP_MIN == HP_MAX) begin
      hp_adv  = hp_q;
      dir_adv = dir_up_q;
    end else if (BOUNCE == 0) begin
      hp_adv = (hp_q == HpMax) ? HpMin : hp_q + 6'd1;
    end else if (dir_up_q) begin
      if (hp_q == HpMax) begin
        dir_adv = 1'b0;
        hp_adv  = hp_q - 6'd1;
      end else begin
        hp_adv  = hp_q + 6'd1;
      end
    end else begin
      if (hp_q == HpMin) begin
        dir_adv = 1'b1;
        hp_adv  = hp_q + 6'd1;
      end else begin
        hp_adv  = hp_q - 6'd1;
      end
    end
  end

  assign tmo_hit = (tmo_q == TmoLast);

  always_comb begin
    state_d     = state_q;
    hp_d        = hp_q;
    dir_up_d    = dir_up_q;
    start_d     = 1'b0;
    step_d      = step_q;
    fail_flag_d = fail_flag_q;
    fail_cnt_d  = fail_cnt_q;
    tmo_d       = tmo_q;
    dwell_d     = dwell_q;

    unique case (state_q)
      StIdle: begin
        if (enable) state_d = StReq;
      end
      StReq: begin
        if (ready) begin
          state_d = StWaitDone;
          start_d = 1'b1;
          tmo_d   = '0;
        end
      end
      StWaitDone: begin
        tmo_d = tmo_q + TW'(1);
        if (tmo_hit) begin
          fail_flag_d = 1'b1;
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          state_d = StReq;
        end else if (reconfig_done) begin
          // A lock seen together with done is only taken from the next cycle on.
          state_d = StWaitLock;
        end
      end
      StWaitLock: begin
        tmo_d = tmo_q + TW'(1);
        if (locked) begin
          state_d = StDwell;
          step_d  = step_q + 16'd1;
          dwell_d = '0;
        end else if (tmo_hit) begin
          fail_flag_d = 1'b1;
          if (fail_cnt_q != 8'hFF) fail_cnt_d = fail_cnt_q + 8'd1;
          state_d = StReq;
        end
      end
      StDwell: begin
        dwell_d = dwell_q + DW'(1);
        if (dwell_q == DwellLast) state_d = StAdvance;
      end
      StAdvance: begin
        hp_d     = hp_adv;
        dir_up_d = dir_adv;
        state_d  = enable ? StReq : StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      hp_q        <= HpMin;
      dir_up_q    <= 1'b1;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      step_q      <= '0;
      fail_flag_q <= 1'b0;
      fail_cnt_q  <= '0;
      tmo_q       <= '0;
      dwell_q     <= '0;
    end else begin
      state_q     <= state_d;
      hp_q        <= hp_d;
      dir_up_q    <= dir_up_d;
      start_q     <= start_d;
      busy_q      <= busy_d;
      step_q      <= step_d;
      fail_flag_q <= fail_flag_d;
      fail_cnt_q  <= fail_cnt_d;
      tmo_q       <= tmo_d;
      dwell_q     <= dwell_d;
    end
  end

  assign half_period    = hp_q;
  assign start_reconfig = start_q;
  assign busy           = busy_q;
  assign step_count     = step_q;
  assign lock_fail      = fail_flag_q;
  assign fail_count     = fail_cnt_q;

endmodule

// File: tb/tb_mmcm_sweep_ctrl.sv
// Directed bench for mmcm_sweep_ctrl: a wrapping and a ping-pong instance share one stimulus.
module tb_mmcm_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        enable;
  logic        ready;
  logic        done;
  logic        locked;

  logic [5:0]  hp,       hp_b;
  logic        start_reconfig, start_b;
  logic        busy,     busy_b;
  logic [15:0] step_count, step_b;
  logic        lock_fail, lock_fail_b;
  logic [7:0]  fail_count, fail_count_b;

  int n_checks = 0;
  int n_errors = 0;
  int n_start  = 0;

  mmcm_sweep_ctrl #(
    .HP_MIN(10), .HP_MAX(12), .DWELL_CYCLES(8), .LOCK_TIMEOUT(16), .BOUNCE(0)
  ) u_dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ready          (ready),
    .reconfig_done  (done),
    .locked         (locked),
    .half_period    (hp),
    .start_reconfig (start_reconfig),
    .busy           (busy),
    .step_count     (step_count),
    .lock_fail      (lock_fail),
    .fail_count     (fail_count)
  );

  mmcm_sweep_ctrl #(
    .HP_MIN(10), .HP_MAX(12), .DWELL_CYCLES(8), .LOCK_TIMEOUT(16), .BOUNCE(1)
  ) u_dut_b (
    .clk            (clk),
    .rst_n          (rst_n),
    .enable         (enable),
    .ready          (ready),
    .reconfig_done  (done),
    .locked         (locked),
    .half_period    (hp_b),
    .start_reconfig (start_b),
    .busy           (busy_b),
    .step_count     (step_b),
    .lock_fail      (lock_fail_b),
    .fail_count     (fail_count_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (start_reconfig === 1'b1) n_start <= n_start + 1;
  end

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Returns the number of extra negedges waited, or -1 if no pulse within budget.
  task automatic wait_start(input int budget, output int lat);
    lat = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (start_reconfig === 1'b1) begin
        lat = k;
        break;
      end
    end
  endtask

  int exp_wrap[6] = '{10, 11, 12, 10, 11, 12};
  int exp_bnc[6]  = '{10, 11, 12, 11, 10, 11};

  initial begin
    int lat;
    int snap;

    rst_n  = 1'b0;
    enable = 1'b0;
    ready  = 1'b0;
    done   = 1'b0;
    locked = 1'b0;
    repeat (3) @(negedge clk);

    check_eq("rst_hp",        hp,             10);
    check_eq("rst_start",     start_reconfig, 0);
    check_eq("rst_busy",      busy,           0);
    check_eq("rst_step",      step_count,     0);
    check_eq("rst_lock_fail", lock_fail,      0);
    check_eq("rst_fail_cnt",  fail_count,     0);

    // Normal sweep; enable dropped during WAIT_LOCK of the last value.
    rst_n  = 1'b1;
    enable = 1'b1;
    ready  = 1'b1;
    for (int i = 0; i < 6; i++) begin
      wait_start(100, lat);
      check_eq($sformatf("t1_seen%0d", i),   int'(lat >= 0), 1);
      check_eq($sformatf("t1_hp%0d", i),     hp,             exp_wrap[i]);
      check_eq($sformatf("t1_hp_b%0d", i),   hp_b,           exp_bnc[i]);
      check_eq($sformatf("t1_pulses%0d", i), n_start,        i);
      check_eq($sformatf("t1_busy%0d", i),   busy,           1);
      repeat (3) @(negedge clk);
      done = 1'b1;
      @(negedge clk);
      done = 1'b0;
      if (i == 5) enable = 1'b0;
      repeat (4) @(negedge clk);
      locked = 1'b1;
      repeat (2) @(negedge clk);
      locked = 1'b0;
      check_eq($sformatf("t1_step%0d", i), step_count, i + 1);
    end
    repeat (20) @(negedge clk);
    check_eq("t5_busy",   busy,           0);
    check_eq("t5_pulses", n_start,        6);
    check_eq("t5_hp",     hp,             10);
    check_eq("t5_hp_b",   hp_b,           12);
    check_eq("t5_step",   step_count,     6);
    check_eq("t5_fails",  fail_count,     0);
    check_eq("t5_start",  start_reconfig, 0);

    // Engine not ready: no pulse and no timeout while stalled in REQ.
    enable = 1'b1;
    ready  = 1'b0;
    repeat (20) @(negedge clk);
    check_eq("t2_pulses", n_start,    6);
    check_eq("t2_fails",  fail_count, 0);
    check_eq("t2_busy",   busy,       1);
    ready = 1'b1;
    wait_start(10, lat);
    check_eq("t2_lat", lat, 0);
    check_eq("t2_hp",  hp,  10);

    // No done, no lock: timeout after 16 cycles, retry at the same value, saturate.
    repeat (15) @(negedge clk);
    check_eq("t3_fail_pre", fail_count, 0);
    @(negedge clk);
    check_eq("t3_fail_one", fail_count, 1);
    check_eq("t3_sticky",   lock_fail,  1);
    wait_start(10, lat);
    check_eq("t3_retry_lat", lat, 0);
    check_eq("t3_retry_hp",  hp,  10);
    repeat (300 * 17) @(negedge clk);
    check_eq("t3_sat",      fail_count,   255);
    check_eq("t3_sat_b",    fail_count_b, 255);
    check_eq("t3_sticky2",  lock_fail,    1);
    check_eq("t3_step",     step_count,   6);

    // Asynchronous reset in WAIT_DONE, then a fresh start.
    wait_start(40, lat);
    check_eq("t6_seen", int'(lat >= 0), 1);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t6_hp",        hp,             10);
    check_eq("t6_hp_b",      hp_b,           10);
    check_eq("t6_busy",      busy,           0);
    check_eq("t6_start",     start_reconfig, 0);
    check_eq("t6_fail_cnt",  fail_count,     0);
    check_eq("t6_lock_fail", lock_fail,      0);
    check_eq("t6_step",      step_count,     0);
    snap = n_start;
    repeat (3) @(negedge clk);
    check_eq("t6_no_pulse", n_start, snap);
    rst_n = 1'b1;
    wait_start(10, lat);
    check_eq("t6_lat",      lat,        1);
    check_eq("t6_new_hp",   hp,         10);
    check_eq("t6_new_fail", fail_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
